// File: rtl/gate_sweep_validator_if.sv
// Handshake/result bundle between the gate sweep validator and its controller plus gate under test.
interface gate_sweep_validator_if #(
  parameter int N_IN  = 2,
  parameter int ERR_W = 16
);
  logic              start;
  logic [2:0]        op;
  logic [N_IN-1:0]   dut_in;
  logic              dut_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_cnt;
  logic [N_IN-1:0]   first_fail_vec;
  logic              first_fail_vld;

  // The master side issues requests and also plays the gate under test.
  modport master (
    output start, op, dut_out,
    input  dut_in, busy, done, pass, err_cnt, first_fail_vec, first_fail_vld
  );

  modport slave (
    input  start, op, dut_out,
    output dut_in, busy, done, pass, err_cnt, first_fail_vec, first_fail_vld
  );
endinterface

// File: rtl/gate_sweep_validator.sv
// Exhaustive self-sequencing checker for an N_IN-input combinational gate.
// Optional feature macro: GATE_SWEEP_STOP_ON_FAIL_EN (end the sweep at the first mismatch).
module gate_sweep_validator #(
  parameter int N_IN       = 2,
  parameter int SETTLE_CYC = 1,
  parameter int ERR_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  gate_sweep_validator_if.slave   bus
);

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    CHECK,
    DONE
  } state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [N_IN-1:0]   vec;
  logic [31:0]       wait_cnt;
  logic [N_IN-1:0]   dut_in_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [ERR_W-1:0]  err_q;
  logic [N_IN-1:0]   ff_vec_q;
  logic              ff_vld_q;
  logic              mismatch;

  // Ops 6 and 7 look only at bit 0, so they behave identically for any N_IN.
  function automatic logic ref_bit(input logic [2:0] sel, input logic [N_IN-1:0] v);
    logic r;
    case (sel)
      3'd0:    r = &v;
      3'd1:    r = |v;
      3'd2:    r = ^v;
      3'd3:    r = ~&v;
      3'd4:    r = ~|v;
      3'd5:    r = ~^v;
      3'd6:    r = v[0];
      default: r = ~v[0];
    endcase
    return r;
  endfunction

  assign mismatch = (bus.dut_out != ref_bit(op_q, dut_in_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      vec      <= '0;
      wait_cnt <= '0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      ff_vec_q <= '0;
      ff_vld_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q     <= bus.op;
            vec      <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            ff_vld_q <= 1'b0;
            ff_vec_q <= '0;
            busy_q   <= 1'b1;
            state    <= APPLY;
          end
        end
        APPLY: begin
          dut_in_q <= vec;
          wait_cnt <= 32'(SETTLE_CYC - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 32'd0) begin
            state <= CHECK;
          end else begin
            wait_cnt <= wait_cnt - 32'd1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            if (err_q != '1) begin
              err_q <= err_q + 1'b1;
            end
            if (!ff_vld_q) begin
              ff_vec_q <= dut_in_q;
              ff_vld_q <= 1'b1;
            end
          end
          // The all-ones compare ends the run, so vec never wraps.
          if ((vec == '1) || (STOP_ON_FAIL && mismatch)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            vec   <= vec + 1'b1;
            state <= APPLY;
          end
        end
        DONE: begin
          pass_q <= (err_q == '0);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dut_in         = dut_in_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_cnt        = err_q;
  assign bus.first_fail_vec = ff_vec_q;
  assign bus.first_fail_vld = ff_vld_q;

endmodule
